// File: rtl/frame_snapshot_writer_if.sv
// Camera-side pixel stream feeding the frame snapshot writer.
interface frame_snapshot_writer_if #(
  parameter int unsigned PIXEL_WIDTH = 4
);
  logic [PIXEL_WIDTH-1:0] pix_data;
  logic                   pix_valid;
  logic                   pix_sof;

  modport master (output pix_data, output pix_valid, output pix_sof);
  modport slave  (input  pix_data, input  pix_valid, input  pix_sof);
endinterface

// File: rtl/frame_snapshot_writer.sv
// Captures one raster-order frame of grayscale pixels into the static BRAM,
// then freezes it (static_bram_rdy=1) until the correlator reports it consumed.
module frame_snapshot_writer #(
  parameter int unsigned VGA_WIDTH      = 640,
  parameter int unsigned VGA_HEIGHT     = 480,
  parameter int unsigned ADDR_WIDTH     = 19,
  parameter int unsigned PIXEL_WIDTH    = 4,
  parameter int unsigned DROP_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  frame_snapshot_writer_if.slave    pix,
  input  logic                      consume_done,
  output logic                      bram_we,
  output logic [ADDR_WIDTH-1:0]     bram_addr,
  output logic [PIXEL_WIDTH-1:0]    bram_data,
  output logic                      static_bram_rdy,
  output logic                      capturing,
  output logic [DROP_CNT_WIDTH-1:0] frames_dropped
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(VGA_WIDTH * VGA_HEIGHT - 1);

  typedef enum logic [1:0] {WAIT_SOF, CAPTURE, HOLD} state_t;

  state_t                    state_q;
  logic                      we_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic [PIXEL_WIDTH-1:0]    data_q;
  logic                      rdy_q;
  logic                      cap_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;

  logic                      accept_d;
  logic [ADDR_WIDTH-1:0]     idx_d;

  // Pixel acceptance and next raster index; addr_q doubles as the pixel counter
  // since it always holds the index of the most recent write.
  always_comb begin
    accept_d = pix.pix_valid &&
               ((state_q == CAPTURE) || ((state_q == WAIT_SOF) && pix.pix_sof));
    idx_d    = pix.pix_sof ? '0 : addr_q + ADDR_WIDTH'(1);
  end

  // Capture FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WAIT_SOF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdy_q   <= 1'b0;
      cap_q   <= 1'b0;
      drop_q  <= '0;
    end else begin
      we_q <= 1'b0;
      if (accept_d) begin
        we_q   <= 1'b1;
        addr_q <= idx_d;
        data_q <= pix.pix_data;
        // rdy rises together with the final write strobe, never ahead of it.
        if (idx_d == LAST_IDX) begin
          state_q <= HOLD;
          rdy_q   <= 1'b1;
          cap_q   <= 1'b0;
        end else begin
          state_q <= CAPTURE;
          cap_q   <= 1'b1;
        end
      end else if (state_q == HOLD) begin
        if (pix.pix_valid && pix.pix_sof && (drop_q != '1)) begin
          drop_q <= drop_q + DROP_CNT_WIDTH'(1);
        end
        if (consume_done) begin
          state_q <= WAIT_SOF;
          rdy_q   <= 1'b0;
        end
      end
    end
  end

  assign bram_we         = we_q;
  assign bram_addr       = addr_q;
  assign bram_data       = data_q;
  assign static_bram_rdy = rdy_q;
  assign capturing       = cap_q;
  assign frames_dropped  = drop_q;

endmodule

// File: tb/tb_frame_snapshot_writer.sv
// Self-checking bench for frame_snapshot_writer on an 8x4 frame.
module tb_frame_snapshot_writer;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int AW   = 5;
  localparam int PW   = 4;
  localparam int LAST = W * H - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic consume_done = 1'b0;

  frame_snapshot_writer_if #(.PIXEL_WIDTH(PW)) pix_if ();

  logic          bram_we,  bram_we2;
  logic [AW-1:0] bram_addr, bram_addr2;
  logic [PW-1:0] bram_data, bram_data2;
  logic          rdy, rdy2, capturing, capturing2;
  logic [7:0]    dropped;
  logic [1:0]    dropped2;

  frame_snapshot_writer #(
    .VGA_WIDTH(W), .VGA_HEIGHT(H), .ADDR_WIDTH(AW),
    .PIXEL_WIDTH(PW), .DROP_CNT_WIDTH(8)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .pix(pix_if.slave), .consume_done(consume_done),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_data(bram_data),
    .static_bram_rdy(rdy), .capturing(capturing), .frames_dropped(dropped)
  );

  frame_snapshot_writer #(
    .VGA_WIDTH(W), .VGA_HEIGHT(H), .ADDR_WIDTH(AW),
    .PIXEL_WIDTH(PW), .DROP_CNT_WIDTH(2)
  ) u_dut2 (
    .clk(clk), .rst_n(rst_n), .pix(pix_if.slave), .consume_done(consume_done),
    .bram_we(bram_we2), .bram_addr(bram_addr2), .bram_data(bram_data2),
    .static_bram_rdy(rdy2), .capturing(capturing2), .frames_dropped(dropped2)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    logic [PW-1:0] data;
    int            due;
  } exp_t;
  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: 0 wait-sof, 1 capture, 2 hold
  int m_st   = 0;
  int m_idx  = 0;
  int m_drop = 0;
  int m_drop2 = 0;
  bit m_rdy  = 1'b0;

  // Write-port monitor: every strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_write: got addr=%0d data=%0d at cyc %0d, required no write",
                 bram_addr, bram_data, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bram_addr !== e.addr || bram_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL write: got addr=%0d data=%0d cyc=%0d, required addr=%0d data=%0d cyc=%0d",
                   bram_addr, bram_data, cyc, e.addr, e.data, e.due);
        end
      end
    end
    n_checks++;
    if (bram_we2 !== bram_we || bram_addr2 !== bram_addr || bram_data2 !== bram_data) begin
      n_fail++;
      $display("FAIL dut2_write: got we=%0b addr=%0d data=%0d, required we=%0b addr=%0d data=%0d",
               bram_we2, bram_addr2, bram_data2, bram_we, bram_addr, bram_data);
    end
  end

  task automatic push_write(input int idx, input logic [PW-1:0] d);
    exp_t e;
    e.addr = AW'(idx);
    e.data = d;
    e.due  = cyc + 1;
    sb.push_back(e);
  endtask

  // One clock of stimulus; model advances, then status outputs are checked.
  task automatic step(input bit v, input bit s, input logic [PW-1:0] d, input bit cd);
    pix_if.pix_valid = v;
    pix_if.pix_sof   = s;
    pix_if.pix_data  = d;
    consume_done     = cd;
    case (m_st)
      0: if (v && s) begin
           m_idx = 0;
           push_write(m_idx, d);
           m_st = 1;
         end
      1: if (v) begin
           m_idx = s ? 0 : m_idx + 1;
           push_write(m_idx, d);
           if (m_idx == LAST) begin
             m_st  = 2;
             m_rdy = 1'b1;
           end
         end
      default: begin
        if (v && s) begin
          if (m_drop < 255) m_drop++;
          if (m_drop2 < 3) m_drop2++;
        end
        if (cd) begin
          m_st  = 0;
          m_rdy = 1'b0;
        end
      end
    endcase
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (rdy !== m_rdy || rdy2 !== m_rdy) begin
      n_fail++;
      $display("FAIL rdy: got %0b/%0b, required %0b at cyc %0d", rdy, rdy2, m_rdy, cyc);
    end
    n_checks++;
    if (capturing !== (m_st == 1) || capturing2 !== (m_st == 1)) begin
      n_fail++;
      $display("FAIL capturing: got %0b/%0b, required %0b at cyc %0d",
               capturing, capturing2, (m_st == 1), cyc);
    end
    n_checks++;
    if (dropped !== 8'(m_drop) || dropped2 !== 2'(m_drop2)) begin
      n_fail++;
      $display("FAIL frames_dropped: got %0d/%0d, required %0d/%0d at cyc %0d",
               dropped, dropped2, m_drop, m_drop2, cyc);
    end
  endtask

  task automatic send_pixels(input int n, input int gap, input bit sof_first,
                             input bit cd, input int off);
    for (int i = 0; i < n; i++) begin
      step(1'b1, sof_first && (i == 0), PW'((i + off) % 16), cd);
      for (int g = 0; g < gap; g++) step(1'b0, 1'b0, PW'(4'hF), cd);
    end
  endtask

  task automatic check_drained(input string tag);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: got %0d writes outstanding, required 0", tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic do_reset(input bit valid_during);
    pix_if.pix_valid = valid_during;
    pix_if.pix_sof   = 1'b0;
    pix_if.pix_data  = 4'hA;
    consume_done     = 1'b0;
    rst_n            = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_st = 0; m_idx = 0; m_drop = 0; m_drop2 = 0; m_rdy = 1'b0;
    n_checks++;
    if (bram_we !== 1'b0 || bram_addr !== '0 || bram_data !== '0 || rdy !== 1'b0 ||
        capturing !== 1'b0 || dropped !== '0 || dropped2 !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got we=%0b addr=%0d data=%0d rdy=%0b cap=%0b drop=%0d/%0d, required all 0",
               bram_we, bram_addr, bram_data, rdy, capturing, dropped, dropped2);
    end
    check_drained("reset");
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    pix_if.pix_valid = 1'b0;
    pix_if.pix_sof   = 1'b0;
    pix_if.pix_data  = '0;
    repeat (2) @(posedge clk);
    do_reset(1'b0);
  endtask

  task automatic test_full_frame();
    step(1'b1, 1'b0, 4'h3, 1'b0);          // non-sof pixel in WAIT_SOF is ignored
    send_pixels(W * H, 0, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("full_frame");
  endtask

  task automatic test_hold_drop();
    for (int f = 0; f < 3; f++) send_pixels(W * H, 0, 1'b1, 1'b0, f);
    n_checks++;
    if (dropped !== 8'd3) begin
      n_fail++;
      $display("FAIL hold_drop3: got %0d, required 3", dropped);
    end
    step(1'b0, 1'b0, '0, 1'b1);            // consume -> rdy low next cycle
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("hold_drop");
  endtask

  task automatic test_gaps();
    send_pixels(W * H, 2, 1'b1, 1'b0, 7);
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("gaps");
  endtask

  task automatic test_consume_with_sof();
    step(1'b1, 1'b1, 4'h9, 1'b1);          // exits HOLD, counted as drop
    step(1'b1, 1'b0, 4'h8, 1'b0);          // non-sof ignored in WAIT_SOF
    send_pixels(W * H, 0, 1'b1, 1'b0, 3);
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("consume_sof");
  endtask

  task automatic test_restart();
    step(1'b0, 1'b0, '0, 1'b1);
    send_pixels(10, 0, 1'b1, 1'b1, 1);     // consume_done ignored outside HOLD
    send_pixels(10, 0, 1'b1, 1'b1, 5);
    send_pixels(W * H, 0, 1'b1, 1'b0, 11);
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("restart");
  endtask

  task automatic test_drop_saturate();
    for (int f = 0; f < 2; f++) send_pixels(4, 1, 1'b1, 1'b0, f);
    n_checks++;
    if (dropped !== 8'd6 || dropped2 !== 2'd3) begin
      n_fail++;
      $display("FAIL drop_saturate: got %0d/%0d, required 6/3", dropped, dropped2);
    end
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_pixels(17, 0, 1'b1, 1'b0, 2);
    do_reset(1'b1);
    send_pixels(W * H, 0, 1'b0, 1'b0, 0);  // no sof: whole frame ignored
    send_pixels(W * H, 0, 1'b1, 1'b0, 4);
    for (int f = 0; f < 5; f++) send_pixels(2, 0, 1'b1, 1'b0, f);
    step(1'b0, 1'b0, '0, 1'b0);
    check_drained("reset_mid");
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_hold_drop();
    test_gaps();
    test_consume_with_sof();
    test_restart();
    test_drop_saturate();
    test_reset_mid();
    repeat (3) step(1'b0, 1'b0, '0, 1'b0);
    check_drained("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
